ibex_ex_seq_ctrl: RTL and testbench
===================================

// Module: ibex_ex_seq_ctrl
// PURPOSE
//  Sequences ibex_ex_block one instruction at a time: accepts issue from ID, drives
//  instr_first_cycle/enable, owns the two 34-bit intermediate-value registers
//  (imd_val) and returns the result to WB over a valid/ready handshake.
//  Sits between the ID-stage issue logic and ibex_ex_block; also covers flush and watchdog.
// PARAMETERS
//  IMD_W       34  width of each intermediate-value register
//  TAG_W       4   width of the instruction tag carried ID->WB
//  MAX_CYCLES  40  EXEC cycles without ex_valid_i before watchdog abort (2..63)
// PORTS
//  clk_i            in   1        clock, all flops on rising edge
//  rst_i            in   1        async reset, active high
//  issue_valid_i    in   1        ID presents an EX instruction
//  issue_tag_i      in   TAG_W    tag of the presented instruction
//  issue_ready_o    out  1        controller accepts issue this cycle
//  kill_i           in   1        flush: abandon current op, drop pending result
//  ex_en_o          out  1        EX block operands valid / op active
//  ex_first_cycle_o out  1        to alu_instr_first_cycle_i
//  ex_valid_i       in   1        ex_valid_o from EX block
//  ex_result_i      in   32       result_ex_o from EX block
//  imd_val_we_i     in   2        imd_val_we_o from EX block
//  imd_val_d_i      in   2*IMD_W  imd_val_d_o from EX block
//  imd_val_q_o      out  2*IMD_W  registered intermediate values to EX block
//  wb_valid_o       out  1        result valid to WB
//  wb_ready_i       in   1        WB takes result
//  wb_result_o      out  32       registered result
//  wb_tag_o         out  TAG_W    tag of wb_result_o
//  busy_o           out  1        state != IDLE
//  wd_err_o         out  1        one-cycle pulse on watchdog abort
//  perf_busy_o      out  32       EXEC-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; wb_valid_o, wd_err_o, ex_en_o, ex_first_cycle_o = 0;
//   wb_result_o, wb_tag_o, imd_val_q_o, cycle counter, perf_busy_o = 0.
//  States IDLE, EXEC, HOLD (2-bit encoded).
//  issue_ready_o = (IDLE | (HOLD & wb_ready_i)) & ~kill_i (combinational).
//  Accept = issue_valid_i & issue_ready_o: latch tag, next state EXEC, cnt<=0.
//  EXEC: ex_en_o=1; ex_first_cycle_o=1 only in first EXEC cycle after accept.
//   ex_valid_i=1 -> wb_result_o<=ex_result_i, wb_tag_o<=tag, wb_valid_o<=1, ->HOLD.
//   Single-cycle ALU op: accept at N, EXEC at N+1, wb_valid_o high at N+2.
//   ex_valid_i=0 -> cnt++ (6-bit, saturating); stay EXEC.
//   cnt==MAX_CYCLES-1 and ex_valid_i=0 -> wd_err_o pulse next cycle, ->IDLE.
//  imd_val: half k (k=0 low IMD_W bits) written from imd_val_d_i only when
//   state==EXEC & imd_val_we_i[k]; else hold. Not cleared on kill or completion.
//  HOLD: wb_valid_o stays 1, result/tag stable until wb_ready_i.
//   wb_ready_i & accept -> EXEC (back-to-back, no bubble); wb_ready_i only -> IDLE.
//  kill_i (any state) wins over all: next state IDLE, wb_valid_o<=0, no accept,
//   no imd write that cycle, no wd_err_o. Reset mid-op equals kill plus imd clear.
//  ex_valid_i / imd_val_we_i ignored outside EXEC.
// CONFIGURATION
//  EX_SEQ_PERF_EN defined: perf_busy_o counts cycles with state==EXEC, wraps at
//   2^32, cleared only by reset.
//  Undefined: counter not built, perf_busy_o tied to 32'h0. Port list identical.
// TESTING
//  1 ALU op: issue tag 3 at cyc 0, ex_valid_i=1 in EXEC, result 32'h1234 -> wb_valid_o
//    at cyc 2, wb_result_o=32'h1234, wb_tag_o=3, ex_first_cycle_o high cyc 1 only.
//  2 Div-like op: ex_valid_i low 36 EXEC cycles with imd_val_we_i=2'b11 each cycle ->
//    imd_val_q_o tracks last imd_val_d_i; result at 37th; no wd_err_o.
//  3 Back-pressure: wb_ready_i=0 for 5 cycles in HOLD, issue_valid_i=1 -> issue_ready_o=0,
//    result stable; wb_ready_i=1 -> same-cycle accept, next cycle EXEC.
//  4 Kill: kill_i in EXEC cycle 4 with issue_valid_i=1 -> IDLE next cycle, issue_ready_o=0
//    in kill cycle, wb_valid_o never rises, imd_val_q_o keeps prior value.
//  5 Watchdog: ex_valid_i held 0 -> wd_err_o one pulse after 40 EXEC cycles, busy_o drops.
//  6 EX_SEQ_PERF_EN: test 1 then test 2 -> perf_busy_o=38; undefined -> perf_busy_o=0.

Source files
------------

// File: rtl/ibex_ex_seq_ctrl.sv
// rtl/ibex_ex_seq_ctrl.sv - one-instruction-at-a-time sequencer between ID issue, ibex_ex_block and WB
// Define EX_SEQ_PERF_EN to build the EXEC-cycle performance counter behind perf_busy_o.
`timescale 1ns/1ps
module ibex_ex_seq_ctrl #(
   parameter int IMD_W      = 34,
   parameter int TAG_W      = 4,
   parameter int MAX_CYCLES = 40
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               issue_valid_i,
   input  logic [TAG_W-1:0]   issue_tag_i,
   output logic               issue_ready_o,
   input  logic               kill_i,
   output logic               ex_en_o,
   output logic               ex_first_cycle_o,
   input  logic               ex_valid_i,
   input  logic [31:0]        ex_result_i,
   input  logic [1:0]         imd_val_we_i,
   input  logic [2*IMD_W-1:0] imd_val_d_i,
   output logic [2*IMD_W-1:0] imd_val_q_o,
   output logic               wb_valid_o,
   input  logic               wb_ready_i,
   output logic [31:0]        wb_result_o,
   output logic [TAG_W-1:0]   wb_tag_o,
   output logic               busy_o,
   output logic               wd_err_o,
   output logic [31:0]        perf_busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_HOLD = 2'b10
   } state_t;

   localparam logic [5:0] LP_WD_LAST = 6'(MAX_CYCLES - 1);

   state_t               r_state;
   logic [TAG_W-1:0]     r_tag;
   logic [5:0]           r_cnt;
   logic                 r_ex_en;
   logic                 r_first;
   logic                 r_wb_valid;
   logic                 r_wd_err;
   logic [31:0]          r_wb_result;
   logic [TAG_W-1:0]     r_wb_tag;
   logic [2*IMD_W-1:0]   r_imd;
   logic                 w_issue_ready;
   logic                 w_accept;

   // A held result may be replaced in the same cycle WB takes it, so HOLD issues without a bubble.
   assign w_issue_ready = ((r_state == S_IDLE) || ((r_state == S_HOLD) && wb_ready_i)) && !kill_i;
   assign w_accept      = issue_valid_i && w_issue_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_tag       <= '0;
         r_cnt       <= '0;
         r_ex_en     <= 1'b0;
         r_first     <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wd_err    <= 1'b0;
         r_wb_result <= '0;
         r_wb_tag    <= '0;
      end else begin
         r_wd_err <= 1'b0;
         if (kill_i) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b0;
            r_ex_en    <= 1'b0;
            r_first    <= 1'b0;
         end else if (w_accept) begin
            r_tag      <= issue_tag_i;
            r_state    <= S_EXEC;
            r_cnt      <= '0;
            r_ex_en    <= 1'b1;
            r_first    <= 1'b1;
            r_wb_valid <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: ;
               S_EXEC: begin
                  r_first <= 1'b0;
                  if (ex_valid_i) begin
                     r_wb_result <= ex_result_i;
                     r_wb_tag    <= r_tag;
                     r_wb_valid  <= 1'b1;
                     r_ex_en     <= 1'b0;
                     r_state     <= S_HOLD;
                  end else if (r_cnt == LP_WD_LAST) begin
                     r_wd_err <= 1'b1;
                     r_ex_en  <= 1'b0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_cnt <= (r_cnt == 6'h3f) ? r_cnt : r_cnt + 6'd1;
                  end
               end
               S_HOLD: begin
                  if (wb_ready_i) begin
                     r_wb_valid <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Intermediate values survive kill and completion; only reset clears them.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_imd <= '0;
      end else if ((r_state == S_EXEC) && !kill_i) begin
         for (int k = 0; k < 2; k++) begin
            if (imd_val_we_i[k]) begin
               r_imd[k*IMD_W +: IMD_W] <= imd_val_d_i[k*IMD_W +: IMD_W];
            end
         end
      end
   end

`ifdef EX_SEQ_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_perf <= '0;
      end else if (r_state == S_EXEC) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_busy_o = r_perf;
`else
   assign perf_busy_o = 32'h0;
`endif

   assign issue_ready_o    = w_issue_ready;
   assign ex_en_o          = r_ex_en;
   assign ex_first_cycle_o = r_first;
   assign imd_val_q_o      = r_imd;
   assign wb_valid_o       = r_wb_valid;
   assign wb_result_o      = r_wb_result;
   assign wb_tag_o         = r_wb_tag;
   assign busy_o           = (r_state != S_IDLE);
   assign wd_err_o         = r_wd_err;

endmodule

// File: tb/tb_ibex_ex_seq_ctrl.sv
// tb/tb_ibex_ex_seq_ctrl.sv - randomized scoreboard bench for ibex_ex_seq_ctrl
`timescale 1ns/1ps
module tb_ibex_ex_seq_ctrl;
   localparam int IMD_W      = 34;
   localparam int TAG_W      = 4;
   localparam int MAX_CYCLES = 40;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               issue_valid = 1'b0;
   logic [TAG_W-1:0]   issue_tag = '0;
   logic               kill = 1'b0;
   logic               ex_valid = 1'b0;
   logic [31:0]        ex_result = '0;
   logic [1:0]         imd_we = '0;
   logic [2*IMD_W-1:0] imd_d = '0;
   logic               wb_ready = 1'b0;
   logic               issue_ready_o, ex_en_o, ex_first_cycle_o, wb_valid_o, busy_o, wd_err_o;
   logic [2*IMD_W-1:0] imd_val_q_o;
   logic [31:0]        wb_result_o, perf_busy_o;
   logic [TAG_W-1:0]   wb_tag_o;

   always #5 clk = ~clk;

   ibex_ex_seq_ctrl #(.IMD_W(IMD_W), .TAG_W(TAG_W), .MAX_CYCLES(MAX_CYCLES)) dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_tag_i(issue_tag), .issue_ready_o(issue_ready_o),
      .kill_i(kill), .ex_en_o(ex_en_o), .ex_first_cycle_o(ex_first_cycle_o),
      .ex_valid_i(ex_valid), .ex_result_i(ex_result),
      .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_val_q_o),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready), .wb_result_o(wb_result_o),
      .wb_tag_o(wb_tag_o), .busy_o(busy_o), .wd_err_o(wd_err_o), .perf_busy_o(perf_busy_o)
   );

   int                    n_checks = 0;
   int                    n_fail = 0;
   logic [TAG_W+31:0]     sb_q[$];
   bit                    pending = 1'b0;
   bit                    exp_wd = 1'b0;
   logic [2*IMD_W-1:0]    m_imd = '0;
   logic [31:0]           m_perf = '0;

   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_perf();
`ifdef EX_SEQ_PERF_EN
      return m_perf;
`else
      return 32'h0;
`endif
   endfunction

   task automatic drive(input bit iv, input logic [TAG_W-1:0] tg, input bit kl, input bit ev,
                        input logic [31:0] res, input logic [1:0] we, input logic [67:0] d, input bit wr);
      issue_valid = iv; issue_tag = tg; kill = kl; ex_valid = ev;
      ex_result = res; imd_we = we; imd_d = d; wb_ready = wr;
   endtask

   task automatic common_checks();
      chk("wd_err", 68'(wd_err_o), 68'(exp_wd));
      chk("imd_val_q", imd_val_q_o, m_imd);
      chk("wb_valid", 68'(wb_valid_o), 68'(pending));
      chk("perf_busy", 68'(perf_busy_o), 68'(exp_perf()));
   endtask

   // Scoreboard monitor: result/tag must match the oldest completed op while wb_valid_o is up.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && wb_valid_o) begin
            if (sb_q.size() == 0) begin
               chk("wb_unexpected", 68'(wb_valid_o), 68'(0));
            end else begin
               chk("wb_result", 68'(wb_result_o), 68'(sb_q[0][31:0]));
               chk("wb_tag", 68'(wb_tag_o), 68'(sb_q[0][TAG_W+31:32]));
               if (wb_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic run_op(input logic [TAG_W-1:0] tag, input int lat, input logic [31:0] res,
                         input int killc, input int bp, input int gap, input bit force_we, input bit pkill);
      int bp_left = bp;
      int gap_left = gap;
      int guard = 0;
      bit acc = 1'b0;
      bit iv, kl, wr, exp_ready;
      logic [1:0] we;
      logic [67:0] d;
      while (!acc) begin
         iv = (gap_left == 0);
         kl = pkill && ($urandom_range(0, 15) == 0);
         wr = kl ? 1'b0 : ((bp_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0));
         d  = {4'($urandom), $urandom, $urandom};
         drive(iv, tag, kl, 1'($urandom), $urandom, 2'($urandom), d, wr);
         @(negedge clk);
         common_checks();
         exp_ready = (!pending || wr) && !kl;
         chk("issue_ready", 68'(issue_ready_o), 68'(exp_ready));
         chk("ex_en_idle", 68'(ex_en_o), 68'(0));
         chk("first_idle", 68'(ex_first_cycle_o), 68'(0));
         chk("busy_idle", 68'(busy_o), 68'(pending));
         @(posedge clk); #1;
         exp_wd = 1'b0;
         if (kl && pending) begin
            pending = 1'b0;
            void'(sb_q.pop_back());
         end else if (pending && wr) begin
            pending = 1'b0;
         end
         if (iv && exp_ready) acc = 1'b1;
         if (bp_left > 0) bp_left--;
         if (gap_left > 0) gap_left--;
         guard++;
         if (!acc && guard >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
            return;
         end
      end
      for (int j = 0; j < MAX_CYCLES; j++) begin
         kl = (j == killc);
         we = force_we ? 2'b11 : 2'($urandom);
         d  = {4'($urandom), $urandom, $urandom};
         drive(1'($urandom), 4'($urandom), kl, (j == lat), (j == lat) ? res : $urandom, we, d, 1'($urandom));
         @(negedge clk);
         common_checks();
         chk("ex_en", 68'(ex_en_o), 68'(1));
         chk("ex_first", 68'(ex_first_cycle_o), 68'(j == 0));
         chk("issue_ready_exec", 68'(issue_ready_o), 68'(0));
         chk("busy_exec", 68'(busy_o), 68'(1));
         @(posedge clk); #1;
         exp_wd = 1'b0;
         m_perf = m_perf + 32'd1;
         if (kl) break;
         if (we[0]) m_imd[IMD_W-1:0] = d[IMD_W-1:0];
         if (we[1]) m_imd[2*IMD_W-1:IMD_W] = d[2*IMD_W-1:IMD_W];
         if (j == lat) begin
            pending = 1'b1;
            sb_q.push_back({tag, res});
            break;
         end
         if (j == MAX_CYCLES - 1) exp_wd = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", 68'(wb_valid_o), 68'(0));
      chk("rst_wd_err", 68'(wd_err_o), 68'(0));
      chk("rst_ex_en", 68'(ex_en_o), 68'(0));
      chk("rst_first", 68'(ex_first_cycle_o), 68'(0));
      chk("rst_busy", 68'(busy_o), 68'(0));
      chk("rst_wb_result", 68'(wb_result_o), 68'(0));
      chk("rst_wb_tag", 68'(wb_tag_o), 68'(0));
      chk("rst_imd", imd_val_q_o, 68'(0));
      chk("rst_perf", 68'(perf_busy_o), 68'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_op(4'd3, 0, 32'h1234, 99, 0, 0, 1'b0, 1'b0);
      run_op(4'd5, 36, 32'hdead_beef, 99, 0, 0, 1'b1, 1'b0);
`ifdef EX_SEQ_PERF_EN
      chk("perf_after_alu_div", 68'(perf_busy_o), 68'(38));
`else
      chk("perf_after_alu_div", 68'(perf_busy_o), 68'(0));
`endif
      run_op(4'd7, 2, 32'h0bad_cafe, 99, 5, 0, 1'b0, 1'b0);
      run_op(4'd9, 10, 32'h5555_aaaa, 4, 2, 0, 1'b0, 1'b0);
      run_op(4'd2, 60, 32'h1, 99, 0, 1, 1'b0, 1'b0);
      run_op(4'd4, 0, 32'h4444, 99, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         int lat, killc;
         lat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 50)) : int'($urandom_range(0, 5));
         killc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lat)) : 99;
         run_op(4'($urandom), lat, $urandom, killc, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'b0, 1'b1);
      end

      for (int c = 0; c < 3; c++) begin
         drive(1'b0, '0, 1'b0, 1'b0, '0, 2'b00, '0, 1'b1);
         @(negedge clk);
         common_checks();
         @(posedge clk); #1;
         exp_wd = 1'b0;
         pending = 1'b0;
      end
      chk("scoreboard_drained", 68'(sb_q.size()), 68'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
